// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - state encodings and MEM control bit positions for the MEM stage
package mem_access_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int MEM_CS_BIT = 1;
  localparam int MEM_WE_BIT = 0;

endpackage

// File: rtl/mem_req_watchdog.sv
// rtl/mem_req_watchdog.sv - counts cycles of an outstanding data-memory request, pulses on expiry
module mem_req_watchdog #(
  parameter int CYC = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(CYC + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (!run_i) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Fires in the CYC-th running cycle; the owner leaves BUSY on it, so r_cnt never wraps.
  assign expire_o = run_i && (r_cnt == CNT_W'(CYC - 1));

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: data-memory req/ack sequencing, pipeline stall, write-back retire
// Optional BUSY abort on missing ack when DMEM_TIMEOUT_EN is defined.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  input  logic [1:0]        mem_ctrl_i,
  input  logic              wb_ctrl_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [REG_W-1:0]  rd_i,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              wb_valid_o,
  output logic              wb_we_o,
  output logic [REG_W-1:0]  wb_rd_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              err_o
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [REG_W-1:0] r_rd;
  logic             w_accept;
  logic             w_alu;
  logic             w_done;
  logic             w_abort;
  logic             w_expire;

  // The write-back source is implied by MEM_cs here, so wb_ctrl_i is not consulted.
  logic w_unused_wb_ctrl;
  assign w_unused_wb_ctrl = wb_ctrl_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_alu       = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    stall_o     = 1'b0;
    case (r_state)
      IDLE: begin
        if (valid_i) begin
          w_accept = mem_ctrl_i[MEM_CS_BIT];
          w_alu    = !mem_ctrl_i[MEM_CS_BIT];
        end
        stall_o = w_accept;
        if (w_accept) begin
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        w_done  = dmem_ack_i;
        w_abort = !dmem_ack_i && w_expire;
        if (w_done || w_abort) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      r_rd         <= '0;
      wb_valid_o   <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_rd_o      <= '0;
      wb_data_o    <= '0;
    end else begin
      wb_valid_o <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_rd_o    <= '0;
      wb_data_o  <= '0;
      if (w_alu) begin
        wb_valid_o <= 1'b1;
        wb_we_o    <= 1'b1;
        wb_rd_o    <= rd_i;
        wb_data_o  <= alu_result_i;
      end
      if (w_accept) begin
        dmem_req_o   <= 1'b1;
        dmem_we_o    <= mem_ctrl_i[MEM_WE_BIT];
        dmem_addr_o  <= alu_result_i;
        dmem_wdata_o <= wdata_i;
        r_rd         <= rd_i;
      end
      if (w_done || w_abort) begin
        dmem_req_o   <= 1'b0;
        dmem_we_o    <= 1'b0;
        dmem_addr_o  <= '0;
        dmem_wdata_o <= '0;
        wb_valid_o   <= 1'b1;
        wb_rd_o      <= r_rd;
        wb_we_o      <= w_done && !dmem_we_o;
        wb_data_o    <= (w_done && !dmem_we_o) ? dmem_rdata_i : '0;
      end
    end
  end

`ifdef DMEM_TIMEOUT_EN
  logic r_err;

  mem_req_watchdog #(
    .CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .run_i    ((r_state == BUSY) && !dmem_ack_i),
    .expire_o (w_expire)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_err <= 1'b0;
    end else if (w_abort) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;

  assign w_expire = 1'b0;
  assign err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage (timeout case under DMEM_TIMEOUT_EN)
module tb_mem_access_stage;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef struct {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
    logic              we;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              valid;
  logic [1:0]        mem_ctrl;
  logic              wb_ctrl;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] wdata;
  logic [REG_W-1:0]  rd;
  logic              stall;
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;
  logic              wb_valid;
  logic              wb_we;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              err;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t sb[$];
  int   retire_cyc[$];

  mem_access_stage #(
    .DATA_W      (DATA_W),
    .REG_W       (REG_W),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .valid_i      (valid),
    .mem_ctrl_i   (mem_ctrl),
    .wb_ctrl_i    (wb_ctrl),
    .alu_result_i (alu_result),
    .wdata_i      (wdata),
    .rd_i         (rd),
    .stall_o      (stall),
    .dmem_req_o   (dmem_req),
    .dmem_we_o    (dmem_we),
    .dmem_addr_o  (dmem_addr),
    .dmem_wdata_o (dmem_wdata),
    .dmem_ack_i   (dmem_ack),
    .dmem_rdata_i (dmem_rdata),
    .wb_valid_o   (wb_valid),
    .wb_we_o      (wb_we),
    .wb_rd_o      (wb_rd),
    .wb_data_o    (wb_data),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (wb_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_retire", wb_valid, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("wb_rd", wb_rd, e.rd);
          check_eq("wb_data", wb_data, e.data);
          check_eq("wb_we", wb_we, e.we);
          retire_cyc.push_back(cyc);
        end
      end else begin
        check_eq("idle_wb_zero", {wb_valid, wb_we, wb_rd, wb_data}, 0);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    valid      = 1'b0;
    mem_ctrl   = 2'bxx;
    wb_ctrl    = 1'bx;
    alu_result = '0;
    wdata      = '0;
    rd         = '0;
  endtask

  task automatic drive_op(input logic [1:0] ctrl, input logic [DATA_W-1:0] res,
                          input logic [DATA_W-1:0] wd, input logic [REG_W-1:0] r);
    valid      = 1'b1;
    mem_ctrl   = ctrl;
    wb_ctrl    = ctrl[1] ? (ctrl[0] ? 1'bz : 1'b0) : 1'b1;
    alu_result = res;
    wdata      = wd;
    rd         = r;
  endtask

  initial begin
    rst_n      = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    drive_idle();
    @(negedge clk);
    check_eq("rst_outputs", {stall, dmem_req, dmem_we, dmem_addr, wb_valid, wb_we, wb_rd, err}, 0);
    check_eq("rst_data", {dmem_wdata, wb_data}, 0);
    rst_n = 1'b1;

    // Reset while a load is outstanding.
    next_cycle();
    drive_op(2'b10, 32'h100, 32'h0, 5'd8);
    next_cycle();
    drive_idle();
    check_eq("t1_req_busy", dmem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t1_async_clear", {dmem_req, stall, wb_valid, wb_we, wb_rd, wb_data, dmem_addr}, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    dmem_ack = 1'b1;
    next_cycle();
    dmem_ack = 1'b0;
    drive_op(2'b00, 32'h11, 32'h0, 5'd9);
    sb.push_back('{rd: 5'd9, data: 32'h11, we: 1'b1});
    #1 check_eq("t1_idle_after_rst", stall, 0);
    next_cycle();
    drive_idle();

    // Back-to-back ALU ops.
    next_cycle();
    retire_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      drive_op(2'b00, 32'h5 + i, 32'h0, REG_W'(1 + i));
      sb.push_back('{rd: REG_W'(1 + i), data: 32'h5 + i, we: 1'b1});
      #1 check_eq("t2_stall", stall, 0);
      next_cycle();
    end
    drive_idle();
    next_cycle();
    next_cycle();
    check_eq("t2_retire_cnt", retire_cyc.size(), 3);
    if (retire_cyc.size() == 3) begin
      check_eq("t2_consec_a", retire_cyc[1] - retire_cyc[0], 1);
      check_eq("t2_consec_b", retire_cyc[2] - retire_cyc[1], 1);
    end

    // Load with ack in the third BUSY cycle.
    drive_op(2'b10, 32'h40, 32'h0, 5'd4);
    sb.push_back('{rd: 5'd4, data: 32'hDEADBEEF, we: 1'b1});
    #1 check_eq("t3_stall_accept", stall, 1);
    next_cycle();
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      check_eq("t3_stall_busy", stall, 1);
      check_eq("t3_req", {dmem_req, dmem_we, dmem_addr}, {1'b1, 1'b0, 32'h40});
      if (i == 2) begin
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
      end
      next_cycle();
    end
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    check_eq("t3_release", {stall, dmem_req}, 0);
    next_cycle();

    // Zero-wait store, next instruction held by upstream under stall.
    drive_op(2'b11, 32'h80, 32'h1234, 5'd5);
    sb.push_back('{rd: 5'd5, data: 32'h0, we: 1'b0});
    next_cycle();
    check_eq("t4_req", {dmem_req, dmem_we, dmem_addr, dmem_wdata}, {1'b1, 1'b1, 32'h80, 32'h1234});
    drive_op(2'b00, 32'h99, 32'h0, 5'd6);
    dmem_ack = 1'b1;
    next_cycle();
    dmem_ack = 1'b0;
    sb.push_back('{rd: 5'd6, data: 32'h99, we: 1'b1});
    check_eq("t4_after", {dmem_req, dmem_we, stall}, 0);
    next_cycle();
    drive_idle();
    next_cycle();

    // Spurious ack while IDLE.
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hBAD;
    next_cycle();
    dmem_ack   = 1'b0;
    check_eq("t5_outputs", {stall, dmem_req, dmem_we, dmem_addr, wb_valid}, 0);
    next_cycle();

`ifdef DMEM_TIMEOUT_EN
    drive_op(2'b10, 32'h200, 32'h0, 5'd7);
    sb.push_back('{rd: 5'd7, data: 32'h0, we: 1'b0});
    next_cycle();
    drive_idle();
    for (int i = 0; i < 4; i++) begin
      check_eq("t6_req_held", dmem_req, 1);
      next_cycle();
    end
    check_eq("t6_abort", {dmem_req, stall, err}, {1'b0, 1'b0, 1'b1});
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h777;
    next_cycle();
    dmem_ack = 1'b0;
    next_cycle();
    next_cycle();
    check_eq("t6_err_sticky", err, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_eq("t6_err_rst", err, 0);
    #4 rst_n = 1'b1;
`else
    check_eq("err_tied", err, 0);
`endif

    next_cycle();
    next_cycle();
    check_eq("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
